sensor_spi_responder: RTL

Sensor-side end of the 5-wire sensor register SPI link (spi_clk, spi_in, spi_write, spi_read, spi_out).
- Write transfer: deserialises the 256-bit register image shifted in by the FPGA-side master and latches it on the spi_write strobe.
- Read transfer: serialises the latched image back on spi_out.
- Use: sensor emulator for board bring-up and loop-back verification of the master, and register-bank front end for the sensor model.
- All link pins are oversampled in the clk_fix domain.

---
 rtl/sensor_spi_pkg.sv | 20 ++
 rtl/sensor_spi_sync.sv | 40 ++++
 rtl/sensor_spi_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sensor_spi_pkg.sv
// Shared types and sizing helpers for the sensor-side register SPI responder.
package sensor_spi_pkg;

    localparam int NUM_BITS_DEF = 256;

    // Bit counter must reach 2*NUM_BITS-1 so over-length writes stay distinguishable.
    function automatic int bit_cnt_width(input int num_bits);
        return $clog2(2 * num_bits);
    endfunction

    localparam int BIT_CNT_W = bit_cnt_width(NUM_BITS_DEF);

    typedef enum logic [3:0] {
        S_IDLE      = 4'b0001,
        S_SHIFT_IN  = 4'b0010,
        S_LATCH     = 4'b0100,
        S_SHIFT_OUT = 4'b1000
    } state_t;

endpackage

// File: rtl/sensor_spi_sync.sv
// Multi-bit input synchroniser with one extra stage for per-bit rise/fall detection.
module sensor_spi_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_fix,
    input  logic             rst_fix_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [STAGES-1:0][WIDTH-1:0] stage_reg;
    logic [WIDTH-1:0]             prev_reg;

    always_ff @(posedge clk_fix or negedge rst_fix_n) begin
        if (!rst_fix_n) begin
            stage_reg <= '0;
            prev_reg  <= '0;
        end else begin
            stage_reg[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
            prev_reg <= stage_reg[STAGES-1];
        end
    end

    assign dout = stage_reg[STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_edge
            assign rise[gi] = dout[gi] & ~prev_reg[gi];
            assign fall[gi] = ~dout[gi] & prev_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/sensor_spi_responder.sv
// Sensor-side responder: shifts in a register image, latches it on spi_write, reads it back on spi_out.
module sensor_spi_responder
    import sensor_spi_pkg::*;
#(
    parameter int                  NUM_BITS    = NUM_BITS_DEF,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [NUM_BITS-1:0] BANK_INIT   = '0
) (
    input  logic                clk_fix,
    input  logic                rst_fix_n,
    input  logic                spi_clk,
    input  logic                spi_in,
    input  logic                spi_write,
    input  logic                spi_read,
    output logic                spi_out,
    output logic [NUM_BITS-1:0] reg_bank,
    output logic                wr_done,
    output logic                wr_len_err,
    output logic                rd_done
);

    localparam int                CNT_W    = bit_cnt_width(NUM_BITS);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(2 * NUM_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NUM_BITS);

    logic [3:0] pin_sync, pin_rise, pin_fall;

    // Bit order: 0 spi_clk, 1 spi_in, 2 spi_write, 3 spi_read (all equal depth keeps their ordering).
    sensor_spi_sync #(
        .WIDTH  (4),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_fix   (clk_fix),
        .rst_fix_n (rst_fix_n),
        .din       ({spi_read, spi_write, spi_in, spi_clk}),
        .dout      (pin_sync),
        .rise      (pin_rise),
        .fall      (pin_fall)
    );

    logic clk_rise, wr_rise, rd_rise, rd_fall, in_sync, read_sync;
    assign clk_rise  = pin_rise[0];
    assign wr_rise   = pin_rise[2];
    assign rd_rise   = pin_rise[3];
    assign rd_fall   = pin_fall[3];
    assign in_sync   = pin_sync[1];
    assign read_sync = pin_sync[3];

    logic unused_edges;
    assign unused_edges = ^{pin_sync[2], pin_sync[0], pin_rise[1], pin_fall[2:0]};

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next, bit_cnt_inc;
    logic [NUM_BITS-1:0] in_sr_reg, in_sr_next;
    logic [NUM_BITS-1:0] out_sr_reg, out_sr_next;
    logic [NUM_BITS-1:0] reg_bank_reg, reg_bank_next;
    logic                spi_out_reg, spi_out_next;
    logic                wr_done_reg, wr_done_next;
    logic                wr_len_err_reg, wr_len_err_next;
    logic                rd_done_reg, rd_done_next;

    always_ff @(posedge clk_fix or negedge rst_fix_n) begin
        if (!rst_fix_n) begin
            state_reg      <= S_IDLE;
            bit_cnt_reg    <= '0;
            in_sr_reg      <= '0;
            out_sr_reg     <= '0;
            reg_bank_reg   <= BANK_INIT;
            spi_out_reg    <= 1'b0;
            wr_done_reg    <= 1'b0;
            wr_len_err_reg <= 1'b0;
            rd_done_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            in_sr_reg      <= in_sr_next;
            out_sr_reg     <= out_sr_next;
            reg_bank_reg   <= reg_bank_next;
            spi_out_reg    <= spi_out_next;
            wr_done_reg    <= wr_done_next;
            wr_len_err_reg <= wr_len_err_next;
            rd_done_reg    <= rd_done_next;
        end
    end

    assign bit_cnt_inc = (bit_cnt_reg == CNT_MAX) ? CNT_MAX : bit_cnt_reg + 1'b1;

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        in_sr_next      = in_sr_reg;
        out_sr_next     = out_sr_reg;
        reg_bank_next   = reg_bank_reg;
        wr_done_next    = 1'b0;
        wr_len_err_next = 1'b0;
        rd_done_next    = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (rd_rise) begin
                    state_next   = S_SHIFT_OUT;
                    out_sr_next  = reg_bank_reg;
                    bit_cnt_next = '0;
                end else if (clk_rise && !read_sync) begin
                    state_next   = S_SHIFT_IN;
                    in_sr_next   = {in_sr_reg[NUM_BITS-2:0], in_sync};
                    bit_cnt_next = CNT_W'(1);
                end else if (wr_rise) begin
                    state_next   = S_LATCH;
                    bit_cnt_next = '0;
                end
            end
            S_SHIFT_IN: begin
                // A coincident final clock edge is shifted before the latch.
                if (clk_rise) begin
                    in_sr_next   = {in_sr_reg[NUM_BITS-2:0], in_sync};
                    bit_cnt_next = bit_cnt_inc;
                end
                if (wr_rise) begin
                    state_next = S_LATCH;
                end
            end
            S_LATCH: begin
                if (bit_cnt_reg == CNT_FULL) begin
                    reg_bank_next = in_sr_reg;
                    wr_done_next  = 1'b1;
                end else begin
                    wr_len_err_next = 1'b1;
                end
                bit_cnt_next = '0;
                state_next   = S_IDLE;
            end
            S_SHIFT_OUT: begin
                if (rd_fall) begin
                    state_next   = S_IDLE;
                    bit_cnt_next = '0;
                    rd_done_next = 1'b1;
                end else if (clk_rise) begin
                    out_sr_next  = {out_sr_reg[NUM_BITS-2:0], 1'b0};
                    bit_cnt_next = bit_cnt_inc;
                end
            end
            default: begin
                state_next   = S_IDLE;
                bit_cnt_next = '0;
            end
        endcase
        // Registered so spi_out moves only on the cycle after a clock edge or read start.
        spi_out_next = (state_next == S_SHIFT_OUT) ? out_sr_next[NUM_BITS-1] : 1'b0;
    end

    assign spi_out    = spi_out_reg;
    assign reg_bank   = reg_bank_reg;
    assign wr_done    = wr_done_reg;
    assign wr_len_err = wr_len_err_reg;
    assign rd_done    = rd_done_reg;

endmodule
